// File: rtl/cache_line_mem_pkg.sv
// Shared types and widths for the cache line memory: FSM states and line/word geometry.
package cache_mem_pkg;

  localparam int LINE_W         = 128;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int M_ADDR_W       = 26;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT
  } state_t;

endpackage

// File: rtl/cache_line_mem_if.sv
// Cache-side request/response bus; the cache drives the master side, the memory the slave side.
interface cache_line_mem_if;

  logic [cache_mem_pkg::M_ADDR_W-1:0]       i_m_addr;
  logic [cache_mem_pkg::WORDS_PER_LINE-1:0] i_m_byte_en;
  logic [cache_mem_pkg::LINE_W-1:0]         i_m_writedata;
  logic                                     i_m_read;
  logic                                     i_m_write;
  logic [cache_mem_pkg::LINE_W-1:0]         o_m_readdata;
  logic                                     o_m_readdata_valid;
  logic                                     o_m_waitrequest;
  logic                                     o_err;

  modport master (
    output i_m_addr, i_m_byte_en, i_m_writedata, i_m_read, i_m_write,
    input  o_m_readdata, o_m_readdata_valid, o_m_waitrequest, o_err
  );

  modport slave (
    input  i_m_addr, i_m_byte_en, i_m_writedata, i_m_read, i_m_write,
    output o_m_readdata, o_m_readdata_valid, o_m_waitrequest, o_err
  );

endinterface

// File: rtl/cache_line_mem_array.sv
// Line storage: one word-enabled write port and one registered read port.
// The contents are deliberately left unreset; only the read register clears.
module cache_mem_array
  import cache_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DEPTH_LOG2-1:0]     wr_idx,
  input  logic [WORDS_PER_LINE-1:0] wr_word_en,
  input  logic [LINE_W-1:0]         wr_data,
  input  logic                      rd_en,
  input  logic [DEPTH_LOG2-1:0]     rd_idx,
  output logic [LINE_W-1:0]         rd_data
);

  logic [LINE_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        if (wr_word_en[k]) mem[wr_idx][k*WORD_W +: WORD_W] <= wr_data[k*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/cache_line_mem.sv
// Fixed-latency 128-bit line memory behind a waitrequest bus.
// Define CACHE_LINE_MEM_STATS_EN to add accepted read/write counters (o_cnt_rd, o_cnt_wr).
module cache_line_mem
  import cache_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6,
  parameter int RD_LAT     = 4,
  parameter int WR_LAT     = 2
) (
  input  logic              clk,
  input  logic              rst,
  cache_line_mem_if.slave   bus
`ifdef CACHE_LINE_MEM_STATS_EN
  ,
  output logic [31:0]       o_cnt_rd,
  output logic [31:0]       o_cnt_wr
`endif
);

  localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

  state_t                  state, state_n;
  logic [3:0]              cnt, cnt_n;
  logic                    valid_n, err_n, do_rd, do_wr;
  logic                    waitreq_q, valid_q, err_q;
  logic [LINE_W-1:0]       rd_line, out_q;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    unused_addr_bits;

  assign idx              = bus.i_m_addr[DEPTH_LOG2-1:0];
  assign unused_addr_bits = ^bus.i_m_addr[M_ADDR_W-1:DEPTH_LOG2];

  cache_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (do_wr),
    .wr_idx     (idx),
    .wr_word_en (bus.i_m_byte_en),
    .wr_data    (bus.i_m_writedata),
    .rd_en      (do_rd),
    .rd_idx     (idx),
    .rd_data    (rd_line)
  );

  // A write wins over a simultaneous read; the dropped read is flagged as a protocol error.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    valid_n = 1'b0;
    err_n   = err_q;
    do_rd   = 1'b0;
    do_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_m_write) begin
          do_wr = 1'b1;
          if (bus.i_m_read) err_n = 1'b1;
          if (WR_LAT > 1) begin
            state_n = WR_WAIT;
            cnt_n   = WR_CNT;
          end
        end else if (bus.i_m_read) begin
          do_rd = 1'b1;
          if (RD_LAT > 1) begin
            state_n = RD_WAIT;
            cnt_n   = RD_CNT;
          end else begin
            valid_n = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_n = IDLE;
          valid_n = 1'b1;
        end
      end
      WR_WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      waitreq_q <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      out_q     <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      waitreq_q <= (state_n != IDLE);
      valid_q   <= valid_n;
      err_q     <= err_n;
      if (valid_n) out_q <= rd_line;
    end
  end

  // With single-cycle reads the read register itself is the returned line.
  assign bus.o_m_readdata       = (RD_LAT == 1) ? rd_line : out_q;
  assign bus.o_m_readdata_valid = valid_q;
  assign bus.o_m_waitrequest    = waitreq_q;
  assign bus.o_err              = err_q;

`ifdef CACHE_LINE_MEM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_cnt_rd <= 32'd0;
      o_cnt_wr <= 32'd0;
    end else begin
      if (do_rd) o_cnt_rd <= o_cnt_rd + 32'd1;
      if (do_wr) o_cnt_wr <= o_cnt_wr + 32'd1;
    end
  end
`endif

endmodule
